// File: rtl/rpn_core.sv
// Integer RPN calculator engine: digit entry, operand stack, add/sub/neg and an
// iterative shift-add multiplier, reporting each key as a one-cycle cmd/data event.
`ifndef OD_N
`define OD_N 16
`endif
`ifndef OC_N
`define OC_N 2
`endif
`ifndef OC_NONE
`define OC_NONE 2'd0
`endif
`ifndef OC_NUM
`define OC_NUM 2'd1
`endif
`ifndef OC_ACK
`define OC_ACK 2'd2
`endif
`ifndef OC_ERR
`define OC_ERR 2'd3
`endif

module rpn_core #(
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             busy,
    output logic [`OD_N-1:0] data,
    output logic [`OC_N-1:0] cmd
);
    localparam int W   = `OD_N;
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(W + 1);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    localparam logic [3:0] K_ADD   = 4'd10;
    localparam logic [3:0] K_SUB   = 4'd11;
    localparam logic [3:0] K_MUL   = 4'd12;
    localparam logic [3:0] K_ENTER = 4'd13;
    localparam logic [3:0] K_NEG   = 4'd14;
    localparam logic [3:0] K_CLR   = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       stk_q [DEPTH];
    logic [W-1:0]       stk_d [DEPTH];
    logic [SPW-1:0]     sp_q, sp_d;
    logic [W-1:0]       entry_q, entry_d;
    logic               ent_act_q, ent_act_d;
    logic [2:0]         ndig_q, ndig_d;
    logic [`OC_N-1:0]   cmd_q, cmd_d;
    logic [W-1:0]       data_q, data_d;
    logic               busy_q, busy_d;
    logic [2*W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]       mplier_q, mplier_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [IW-1:0]      top_idx, sec_idx, res_idx;
    logic [SPW-1:0]     res_sp;
    logic [W-1:0]       top_val, sec_val, x_val, y_val, x_mag, y_mag;
    logic               bin_ok;
    logic [W:0]         sum_w, diff_w;
    logic [W-1:0]       arith_res;
    logic               arith_ovf;
    logic [W-1:0]       dig_base, dig_ext, dig_mul, dig_val;
    logic [2:0]         dig_nd;
    logic [W-1:0]       neg_src, neg_res;
    logic               neg_ok;
    logic [W-1:0]       enter_val;
    logic               prod_fit;
    logic [W-1:0]       mul_res;

    // Operand selection and datapath results shared by all key handlers.
    always_comb begin
        top_idx = IW'(sp_q - SPW'(1));
        sec_idx = IW'(sp_q - SPW'(2));
        top_val = stk_q[top_idx];
        sec_val = stk_q[sec_idx];
        x_val   = ent_act_q ? entry_q : top_val;
        y_val   = ent_act_q ? top_val : sec_val;
        bin_ok  = (ent_act_q && (sp_q >= SPW'(1))) || (sp_q >= SPW'(2));
        // The result lands where Y was; X is either the entry or the old top.
        res_idx = ent_act_q ? top_idx : sec_idx;
        res_sp  = ent_act_q ? sp_q : (sp_q - SPW'(1));
        x_mag   = x_val[W-1] ? ({W{1'b0}} - x_val) : x_val;
        y_mag   = y_val[W-1] ? ({W{1'b0}} - y_val) : y_val;

        sum_w     = {y_val[W-1], y_val} + {x_val[W-1], x_val};
        diff_w    = {y_val[W-1], y_val} - {x_val[W-1], x_val};
        arith_res = (key_code == K_SUB) ? diff_w[W-1:0] : sum_w[W-1:0];
        arith_ovf = (key_code == K_SUB) ? (diff_w[W] ^ diff_w[W-1])
                                        : (sum_w[W] ^ sum_w[W-1]);

        // A digit after any completed operation starts a fresh positive entry.
        dig_base = ent_act_q ? entry_q : {W{1'b0}};
        dig_nd   = ent_act_q ? ndig_q : 3'd0;
        dig_ext  = {{(W-4){1'b0}}, key_code};
        dig_mul  = dig_base * W'(10);
        dig_val  = dig_base[W-1] ? (dig_mul - dig_ext) : (dig_mul + dig_ext);

        neg_src = ent_act_q ? entry_q : top_val;
        neg_res = {W{1'b0}} - neg_src;
        neg_ok  = (ent_act_q || (sp_q >= SPW'(1))) && (neg_src != MIN_VAL);

        enter_val = ent_act_q ? entry_q
                  : ((sp_q == {SPW{1'b0}}) ? {W{1'b0}} : top_val);

        prod_fit = (acc_q[2*W-1:W-1] == {(W+1){1'b0}})
                || (neg_q && (acc_q == {{W{1'b0}}, MIN_VAL}));
        mul_res  = neg_q ? ({W{1'b0}} - acc_q[W-1:0]) : acc_q[W-1:0];
    end

    // Next-state logic: key decode in IDLE, multiplier iteration, result commit.
    always_comb begin
        state_d   = state_q;
        stk_d     = stk_q;
        sp_d      = sp_q;
        entry_d   = entry_q;
        ent_act_d = ent_act_q;
        ndig_d    = ndig_q;
        cmd_d     = `OC_NONE;
        data_d    = data_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    case (key_code)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                        4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                            if (dig_nd == 3'd4) begin
                                cmd_d = `OC_ERR;
                            end else begin
                                entry_d   = dig_val;
                                ndig_d    = dig_nd + 3'd1;
                                ent_act_d = 1'b1;
                                cmd_d     = `OC_NUM;
                                data_d    = dig_val;
                            end
                        end
                        K_ADD, K_SUB: begin
                            if (!bin_ok || arith_ovf) begin
                                cmd_d = `OC_ERR;
                            end else begin
                                stk_d[res_idx] = arith_res;
                                sp_d           = res_sp;
                                ent_act_d      = 1'b0;
                                ndig_d         = 3'd0;
                                cmd_d          = `OC_NUM;
                                data_d         = arith_res;
                            end
                        end
                        K_MUL: begin
                            if (!bin_ok) begin
                                cmd_d = `OC_ERR;
                            end else begin
                                state_d  = S_MUL;
                                mcand_d  = {{W{1'b0}}, y_mag};
                                mplier_d = x_mag;
                                acc_d    = {(2*W){1'b0}};
                                neg_d    = x_val[W-1] ^ y_val[W-1];
                                cnt_d    = {CW{1'b0}};
                            end
                        end
                        K_ENTER: begin
                            if (sp_q == SPW'(DEPTH)) begin
                                cmd_d = `OC_ERR;
                            end else begin
                                stk_d[IW'(sp_q)] = enter_val;
                                sp_d             = sp_q + SPW'(1);
                                ent_act_d        = 1'b0;
                                ndig_d           = 3'd0;
                                cmd_d            = `OC_ACK;
                            end
                        end
                        K_NEG: begin
                            if (!neg_ok) begin
                                cmd_d = `OC_ERR;
                            end else if (ent_act_q) begin
                                entry_d = neg_res;
                                cmd_d   = `OC_NUM;
                                data_d  = neg_res;
                            end else begin
                                stk_d[top_idx] = neg_res;
                                cmd_d          = `OC_NUM;
                                data_d         = neg_res;
                            end
                        end
                        K_CLR: begin
                            sp_d      = {SPW{1'b0}};
                            entry_d   = {W{1'b0}};
                            ent_act_d = 1'b0;
                            ndig_d    = 3'd0;
                            cmd_d     = `OC_NUM;
                            data_d    = {W{1'b0}};
                        end
                        default: begin
                            cmd_d = `OC_ERR;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (prod_fit) begin
                    stk_d[res_idx] = mul_res;
                    sp_d           = res_sp;
                    ent_act_d      = 1'b0;
                    ndig_d         = 3'd0;
                    cmd_d          = `OC_NUM;
                    data_d         = mul_res;
                end else begin
                    cmd_d = `OC_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= {W{1'b0}};
            end
            sp_q      <= {SPW{1'b0}};
            entry_q   <= {W{1'b0}};
            ent_act_q <= 1'b0;
            ndig_q    <= 3'd0;
            cmd_q     <= `OC_NONE;
            data_q    <= {W{1'b0}};
            busy_q    <= 1'b0;
            mcand_q   <= {(2*W){1'b0}};
            mplier_q  <= {W{1'b0}};
            acc_q     <= {(2*W){1'b0}};
            neg_q     <= 1'b0;
            cnt_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            stk_q     <= stk_d;
            sp_q      <= sp_d;
            entry_q   <= entry_d;
            ent_act_q <= ent_act_d;
            ndig_q    <= ndig_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign data = data_q;
    assign cmd  = cmd_q;

endmodule

// File: tb/tb_rpn_core.sv
// Directed-vector bench for rpn_core: key sequences with hand-computed events.
`ifndef OD_N
`define OD_N 16
`endif
`ifndef OC_N
`define OC_N 2
`endif
`ifndef OC_NONE
`define OC_NONE 2'd0
`endif
`ifndef OC_NUM
`define OC_NUM 2'd1
`endif
`ifndef OC_ACK
`define OC_ACK 2'd2
`endif
`ifndef OC_ERR
`define OC_ERR 2'd3
`endif

module tb_rpn_core;
    localparam int W = 16;

    localparam logic [1:0] NONE = `OC_NONE;
    localparam logic [1:0] NUM  = `OC_NUM;
    localparam logic [1:0] ACK  = `OC_ACK;
    localparam logic [1:0] ERR  = `OC_ERR;

    localparam logic [3:0] ADD = 4'd10;
    localparam logic [3:0] SUB = 4'd11;
    localparam logic [3:0] MUL = 4'd12;
    localparam logic [3:0] ENT = 4'd13;
    localparam logic [3:0] NEG = 4'd14;
    localparam logic [3:0] CLR = 4'd15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_valid = 1'b0;
    logic [3:0]       key_code = 4'd0;
    logic             busy;
    logic [`OD_N-1:0] data;
    logic [`OC_N-1:0] cmd;

    int n_vec  = 0;
    int n_miss = 0;

    rpn_core #(.DEPTH(4)) dut (
        .Clock     (clk),
        .Reset     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .busy      (busy),
        .data      (data),
        .cmd       (cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one key for one cycle (entered at a negedge) and check its event.
    task automatic key_step(input string tag, input logic [3:0] k,
                            input logic [1:0] ec, input logic [15:0] ed);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        chk({tag, ".cmd"}, {30'd0, cmd}, {30'd0, ec});
        chk({tag, ".data"}, {16'd0, data}, {16'd0, ed});
    endtask

    task automatic idle_chk(input string tag);
        key_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".idle"}, {30'd0, cmd}, {30'd0, NONE});
    endtask

    // MUL key, then W+1 busy cycles, then the result event.
    task automatic mul_step(input string tag, input logic [1:0] ec, input logic [15:0] ed);
        key_valid = 1'b1;
        key_code  = MUL;
        @(negedge clk);
        key_valid = 1'b0;
        chk({tag, ".busy1"}, {31'd0, busy}, 32'd1);
        repeat (W) @(negedge clk);
        chk({tag, ".busyW1"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk({tag, ".cmd"}, {30'd0, cmd}, {30'd0, ec});
        chk({tag, ".data"}, {16'd0, data}, {16'd0, ed});
        chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.cmd", {30'd0, cmd}, {30'd0, NONE});
        chk("rst.data", {16'd0, data}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // digit entry, 5th digit rejected, entry kept
        key_step("d1", 4'd1, NUM, 16'd1);
        key_step("d2", 4'd2, NUM, 16'd12);
        key_step("d3", 4'd3, NUM, 16'd123);
        key_step("d4", 4'd4, NUM, 16'd1234);
        key_step("d5", 4'd5, ERR, 16'd1234);
        key_step("neg_ent", NEG, NUM, 16'hFB2E);
        key_step("clr1", CLR, NUM, 16'd0);
        idle_chk("after_clr1");

        // ENTER / ADD
        key_step("a1", 4'd1, NUM, 16'd1);
        key_step("a2", 4'd2, NUM, 16'd12);
        key_step("aent", ENT, ACK, 16'd12);
        key_step("a3", 4'd3, NUM, 16'd3);
        key_step("a4", 4'd4, NUM, 16'd34);
        key_step("add", ADD, NUM, 16'd46);
        key_step("dup", ENT, ACK, 16'd46);
        key_step("add2", ADD, NUM, 16'd92);
        key_step("add_err", ADD, ERR, 16'd92);
        key_step("clr2", CLR, NUM, 16'd0);

        // SUB ordering, NEG in place, operand errors
        key_step("s5", 4'd5, NUM, 16'd5);
        key_step("sent", ENT, ACK, 16'd5);
        key_step("s7", 4'd7, NUM, 16'd7);
        key_step("sub", SUB, NUM, 16'hFFFE);
        key_step("neg_top", NEG, NUM, 16'd2);
        key_step("add_sp1", ADD, ERR, 16'd2);
        key_step("clr3", CLR, NUM, 16'd0);
        key_step("add_sp0", ADD, ERR, 16'd0);
        key_step("neg_none", NEG, ERR, 16'd0);

        // MUL 123*45 with keys during busy and in the FIN cycle
        key_step("m1", 4'd1, NUM, 16'd1);
        key_step("m2", 4'd2, NUM, 16'd12);
        key_step("m3", 4'd3, NUM, 16'd123);
        key_step("ment", ENT, ACK, 16'd123);
        key_step("m4", 4'd4, NUM, 16'd4);
        key_step("m5", 4'd5, NUM, 16'd45);
        key_valid = 1'b1;
        key_code  = MUL;
        @(negedge clk);
        for (int j = 1; j <= W + 1; j++) begin
            chk("mul.busy", {31'd0, busy}, 32'd1);
            chk("mul.quiet", {30'd0, cmd}, {30'd0, NONE});
            key_valid = (j == 3) || (j == W + 1);
            key_code  = 4'd9;
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk("mul.cmd", {30'd0, cmd}, {30'd0, NUM});
        chk("mul.data", {16'd0, data}, 32'd5535);
        chk("mul.busy_end", {31'd0, busy}, 32'd0);
        idle_chk("after_mul");

        // MUL overflow leaves stack and entry intact
        key_step("o3", 4'd3, NUM, 16'd3);
        key_step("o30", 4'd0, NUM, 16'd30);
        key_step("o300", 4'd0, NUM, 16'd300);
        key_step("oent", ENT, ACK, 16'd300);
        key_step("o2", 4'd2, NUM, 16'd2);
        key_step("o20", 4'd0, NUM, 16'd20);
        key_step("o200", 4'd0, NUM, 16'd200);
        mul_step("mul_ovf", ERR, 16'd200);
        key_step("post_ovf_add", ADD, NUM, 16'd500);
        key_step("post_ovf_add2", ADD, NUM, 16'd6035);

        // signed products, including the most negative result
        key_step("clr4", CLR, NUM, 16'd0);
        key_step("n7", 4'd7, NUM, 16'd7);
        key_step("nneg", NEG, NUM, 16'hFFF9);
        key_step("nent", ENT, ACK, 16'hFFF9);
        key_step("n6", 4'd6, NUM, 16'd6);
        mul_step("mul_neg", NUM, 16'hFFD6);
        key_step("b1", 4'd1, NUM, 16'd1);
        key_step("b12", 4'd2, NUM, 16'd12);
        key_step("b128", 4'd8, NUM, 16'd128);
        key_step("bneg", NEG, NUM, 16'hFF80);
        key_step("bent", ENT, ACK, 16'hFF80);
        key_step("c2", 4'd2, NUM, 16'd2);
        key_step("c25", 4'd5, NUM, 16'd25);
        key_step("c256", 4'd6, NUM, 16'd256);
        mul_step("mul_min", NUM, 16'h8000);

        // ADD overflow leaves stack intact
        key_step("e9", 4'd9, NUM, 16'd9);
        key_step("e99", 4'd9, NUM, 16'd99);
        key_step("e999", 4'd9, NUM, 16'd999);
        key_step("e9999", 4'd9, NUM, 16'd9999);
        key_step("eent", ENT, ACK, 16'd9999);
        key_step("e3", 4'd3, NUM, 16'd3);
        mul_step("mul_big", NUM, 16'd29997);
        key_step("bdup", ENT, ACK, 16'd29997);
        key_step("add_ovf", ADD, ERR, 16'd29997);
        key_step("neg_after_ovf", NEG, NUM, 16'h8AD3);
        key_step("add_zero", ADD, NUM, 16'd0);

        // stack full
        key_step("clr5", CLR, NUM, 16'd0);
        key_step("push1", ENT, ACK, 16'd0);
        key_step("push2", ENT, ACK, 16'd0);
        key_step("push3", ENT, ACK, 16'd0);
        key_step("push4", ENT, ACK, 16'd0);
        key_step("push5", ENT, ERR, 16'd0);
        key_step("clr6", CLR, NUM, 16'd0);

        // reset in the middle of a multiply
        key_step("r3", 4'd3, NUM, 16'd3);
        key_step("rent", ENT, ACK, 16'd3);
        key_step("r4", 4'd4, NUM, 16'd4);
        key_valid = 1'b1;
        key_code  = MUL;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rmul.busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmul.busy", {31'd0, busy}, 32'd0);
        chk("rmul.cmd", {30'd0, cmd}, {30'd0, NONE});
        chk("rmul.data", {16'd0, data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        key_step("rmul.sp0", ADD, ERR, 16'd0);
        key_step("rmul.d7", 4'd7, NUM, 16'd7);
        repeat (W + 4) @(negedge clk);
        chk("rmul.no_event", {30'd0, cmd}, {30'd0, NONE});
        chk("rmul.no_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
